softmax_max_stage: RTL and testbench
====================================

Name: softmax_max_stage

Overview:
- Front end of the softmax datapath, directly upstream of the Subtractor.
- Buffers one score vector, finds its unsigned maximum, then replays every element paired with that maximum.
- Downstream wiring is Subtractor.a = out_max, Subtractor.b = out_elem, so the Subtractor computes max - x >= 0 with no wrap.
- The result feeds the exponent stage.

Parameters:
- BITWIDTH, 16, element width; must match the Subtractor's BITWIDTH.
- MAX_LEN, 64, maximum vector length (buffer depth, >= 2).
- CNT_W, $clog2(MAX_LEN+1), width of the length and index counters (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  stage accepts an element.
- in_data  input  BITWIDTH  unsigned score element.
- in_last  input  1  marks the final element of a vector.
- out_valid  output  1  output pair valid.
- out_ready  input  1  downstream accepts the pair.
- out_max  output  BITWIDTH  maximum of the current vector.
- out_elem  output  BITWIDTH  element i of the current vector, in arrival order.
- out_last  output  1  marks the final pair of a vector.
- len_err  output  1  sticky flag: a vector exceeded MAX_LEN and was truncated.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = COLLECT.
  - in_ready = 1 (it is combinational, (state == COLLECT)).
  - out_valid = 0, out_last = 0, out_max = 0, out_elem = 0, len_err = 0.
  - Internal counters (wr_cnt, rd_idx, len) = 0.
  - Buffer contents are don't-care.
- Reset mid-operation: any partial or pending vector is discarded; the stage returns to COLLECT.
- COLLECT state:
  - An element is accepted when in_valid && in_ready. On acceptance: buf[wr_cnt] <= in_data, then wr_cnt++.
  - Max update: the first element of a vector (wr_cnt == 0) loads max unconditionally. Later elements update max when in_data > max (unsigned compare). Ties keep the existing max.
  - The first accepted element of each vector clears len_err.
  - Acceptance with in_last = 1: len <= wr_cnt+1, rd_idx <= 0, wr_cnt <= 0, go to EMIT.
  - Acceptance with wr_cnt == MAX_LEN-1 and in_last = 0: treat as forced last, set len_err <= 1, go to EMIT.
  - After truncation, in_ready is 0 during EMIT, so the remaining source beats stall. When COLLECT resumes, those beats are accepted as a new vector; the upstream must drain or reset.
- EMIT state:
  - in_ready = 0.
  - out_valid rises on the cycle after the last element is accepted (latency 1 clock from the in_last handshake to the first out_valid).
  - Each cycle: out_elem = buf[rd_idx], out_max = max, out_last = (rd_idx == len-1). All outputs are registered.
  - A transfer happens when out_valid && out_ready; then rd_idx++ and the next pair is presented on the next cycle. Full throughput of 1 pair/clock when out_ready is held high.
  - Stall (out_valid && !out_ready): all out_* hold stable; out_valid never drops without a transfer.
  - Transfer with out_last = 1: the next cycle has out_valid = 0, out_last = 0, state = COLLECT, in_ready = 1.
  - out_max holds its value after the vector until the next vector overwrites it.
- Arithmetic and widths:
  - Compare is unsigned and full BITWIDTH; there is no arithmetic on data.
  - Counters are CNT_W bits and never wrap: wr_cnt is capped by the forced-last rule; rd_idx is bounded by len.
- Single-element vector: len = 1, one pair with out_last = 1 and out_elem == out_max.
- The upstream may hold in_valid continuously; no input bubbles are required between vectors beyond the EMIT period.

Test Plan:
- Basic: vector {3, 9, 2, 9, 5} with in_last on 5, out_ready = 1 -> pairs (9,3), (9,9), (9,2), (9,9), (9,5); out_last only on the 5th; first out_valid exactly 1 cycle after the in_last handshake; in_ready = 1 the cycle after the last transfer.
- Backpressure: same vector, out_ready toggled 1,0,0,1,... -> out_* stable through every stall; same 5 pairs in order; no pair duplicated or dropped.
- Edge values: single element 16'hFFFF, then vector {0, 0} -> pair (FFFF, FFFF, last = 1), then (0,0), (0,0, last); downstream Subtractor sees max - x = 0 throughout.
- Overflow: MAX_LEN = 4, send 6 elements {1,7,3,4,8,2} -> len_err = 1; pairs (7,1), (7,7), (7,3), (7,4, last); 8 and 2 are then collected as the next vector with len_err cleared on the first of them.
- Async reset: assert rst_n = 0 mid-EMIT after 2 of 5 pairs, asynchronously between clock edges -> out_valid = 0, out_last = 0, len_err = 0, in_ready = 1 immediately; a new vector {4, 1} afterwards yields (4,4), (4,1, last).
- Back-to-back: two vectors streamed with in_valid held high -> the second is accepted starting the cycle after the first vector's out_last transfer; its max is independent of the first vector.

Source files
------------

// File: rtl/softmax_max_stage_if.sv
// Stream interface for softmax_max_stage.
//   in_valid/in_ready/in_data/in_last       : score elements into the stage
//   out_valid/out_ready/out_max/out_elem/out_last : (max, element) pairs out
//   len_err                                  : sticky truncation flag
// slave  : view taken by the stage itself
// master : view taken by the surrounding environment (source + sink)
interface softmax_max_stage_if #(
  parameter int BITWIDTH = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_max;
  logic [BITWIDTH-1:0] out_elem;
  logic                out_last;
  logic                len_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_elem, out_last, len_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_elem, out_last, len_err
  );
endinterface

// File: rtl/softmax_max_stage.sv
// Softmax max stage: buffers one unsigned score vector, tracks its maximum,
// then replays every element paired with that maximum so the downstream
// Subtractor (a = out_max, b = out_elem) always sees max - x >= 0.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : softmax_max_stage_if.slave (input stream, output pair stream,
//            sticky len_err flag)
module softmax_max_stage #(
  parameter int BITWIDTH = 16,
  parameter int MAX_LEN  = 64,
  parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  softmax_max_stage_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [BITWIDTH-1:0] max_q, max_d;
  logic [BITWIDTH-1:0] out_max_q, out_max_d;
  logic [BITWIDTH-1:0] out_elem_q, out_elem_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                len_err_q, len_err_d;
  logic [BITWIDTH-1:0] mem_q [MAX_LEN];

  logic                in_fire;
  logic                out_fire;
  logic                forced_last;
  logic                end_vec;
  logic [BITWIDTH-1:0] max_nxt;
  logic [CNT_W-1:0]    wr_nxt;
  logic [CNT_W-1:0]    rd_nxt;

  assign in_fire     = bus.in_valid && (state_q == COLLECT);
  assign out_fire    = out_valid_q && bus.out_ready;
  assign forced_last = (wr_cnt_q == CNT_W'(MAX_LEN - 1)) && !bus.in_last;
  assign end_vec     = bus.in_last || forced_last;
  // First element of a vector loads unconditionally; ties keep the old max.
  assign max_nxt     = ((wr_cnt_q == '0) || (bus.in_data > max_q)) ? bus.in_data : max_q;
  assign wr_nxt      = wr_cnt_q + CNT_W'(1);
  assign rd_nxt      = rd_idx_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    len_d       = len_q;
    max_d       = max_q;
    out_max_d   = out_max_q;
    out_elem_d  = out_elem_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    len_err_d   = len_err_q;
    unique case (state_q)
      COLLECT: begin
        if (in_fire) begin
          max_d    = max_nxt;
          wr_cnt_d = wr_nxt;
          if (wr_cnt_q == '0) begin
            len_err_d = 1'b0;
          end
          if (end_vec) begin
            if (forced_last) begin
              len_err_d = 1'b1;
            end
            len_d       = wr_nxt;
            rd_idx_d    = '0;
            wr_cnt_d    = '0;
            state_d     = EMIT;
            // First pair is registered here so out_valid rises one clock
            // after the final handshake; element 0 bypasses the buffer when
            // it is being written on this same edge.
            out_valid_d = 1'b1;
            out_max_d   = max_nxt;
            out_elem_d  = (wr_cnt_q == '0) ? bus.in_data : mem_q[0];
            out_last_d  = (wr_cnt_q == '0);
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_idx_d    = '0;
            state_d     = COLLECT;
          end else begin
            rd_idx_d   = rd_nxt;
            out_elem_d = mem_q[rd_nxt[AW-1:0]];
            out_last_d = (rd_nxt == len_q - CNT_W'(1));
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      len_q       <= '0;
      max_q       <= '0;
      out_max_q   <= '0;
      out_elem_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      len_q       <= len_d;
      max_q       <= max_d;
      out_max_q   <= out_max_d;
      out_elem_q  <= out_elem_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
    end
  end

  // Vector storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_cnt_q[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_elem  = out_elem_q;
  assign bus.out_last  = out_last_q;
  assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_softmax_max_stage.sv
// Bench for softmax_max_stage: two instances (default MAX_LEN and MAX_LEN=4)
// share one stimulus driver; sel picks the active instance.
module tb_softmax_max_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        d_valid = 1'b0;
  logic [15:0] d_data = '0;
  logic        d_last = 1'b0;
  logic        d_ready = 1'b0;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  always #5 clk = ~clk;

  softmax_max_stage_if #(.BITWIDTH(16)) ifa ();
  softmax_max_stage_if #(.BITWIDTH(16)) ifb ();

  softmax_max_stage #(.BITWIDTH(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  softmax_max_stage #(.BITWIDTH(16), .MAX_LEN(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.in_valid  = d_valid & ~sel;
  assign ifb.in_valid  = d_valid & sel;
  assign ifa.in_data   = d_data;
  assign ifb.in_data   = d_data;
  assign ifa.in_last   = d_last;
  assign ifb.in_last   = d_last;
  assign ifa.out_ready = d_ready;
  assign ifb.out_ready = d_ready;

  logic        o_in_ready, o_out_valid, o_out_last, o_len_err;
  logic [15:0] o_out_max, o_out_elem;
  assign o_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
  assign o_out_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign o_out_last  = sel ? ifb.out_last  : ifa.out_last;
  assign o_len_err   = sel ? ifb.len_err   : ifa.len_err;
  assign o_out_max   = sel ? ifb.out_max   : ifa.out_max;
  assign o_out_elem  = sel ? ifb.out_elem  : ifa.out_elem;

  typedef struct {
    logic [15:0] d;
    bit          last;
  } in_t;

  typedef struct {
    logic [15:0] m;
    logic [15:0] e;
    bit          last;
    bit          err;
  } exp_t;

  in_t  in_q[$];
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input bit last);
    in_q.push_back('{d: d, last: last});
  endtask

  // Reference: split the stream into vectors (on last or at ml elements),
  // take each vector's unsigned maximum, pair it with every element.
  function automatic void build(input int ml);
    logic [15:0] v[$];
    logic [15:0] m;
    bit          trunc;
    exp_q.delete();
    foreach (in_q[i]) begin
      v.push_back(in_q[i].d);
      if (in_q[i].last || v.size() == ml) begin
        trunc = !in_q[i].last;
        m = 0;
        foreach (v[j]) if (v[j] > m) m = v[j];
        foreach (v[j]) exp_q.push_back('{m: m, e: v[j], last: (j == v.size() - 1), err: trunc});
        v.delete();
      end
    end
  endfunction

  function automatic logic [15:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // mode 0: ready high; 1: ready pattern 1,0,0; 2: random ready.
  // stop_after > 0 returns after that many transfers with the sink stalled.
  task automatic run(input int mode, input int ml, input int stop_after, input int budget);
    int          cycles = 0;
    int          xfers = 0;
    int          acc = 0;
    bit          stall_prev = 0;
    bit          chk_first = 0;
    bit          chk_after = 0;
    logic [15:0] s_max, s_elem;
    logic        s_last;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cycles < budget &&
           !(stop_after > 0 && xfers >= stop_after)) begin
      @(negedge clk);
      cycles++;
      if (chk_first) chk("first_valid_latency", o_out_valid, 1);
      if (chk_after) begin
        chk("in_ready_after_last", o_in_ready, 1);
        chk("out_valid_after_last", o_out_valid, 0);
        chk("out_last_after_last", o_out_last, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", o_out_valid, 1);
        chk("stall_max", o_out_max, s_max);
        chk("stall_elem", o_out_elem, s_elem);
        chk("stall_last", o_out_last, s_last);
      end
      chk_first = 0;
      chk_after = 0;
      d_valid = (in_q.size() > 0);
      d_data  = d_valid ? in_q[0].d : 16'h0;
      d_last  = d_valid ? in_q[0].last : 1'b0;
      case (mode)
        0:       d_ready = 1'b1;
        1:       d_ready = ((cycles - 1) % 3 == 0);
        default: d_ready = 1'($urandom_range(0, 1));
      endcase
      if (d_valid && o_in_ready) begin
        acc++;
        if (in_q[0].last || acc == ml) begin
          chk_first = 1;
          acc = 0;
        end
        void'(in_q.pop_front());
      end
      if (o_out_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", o_out_valid, 0);
        end else begin
          chk("pair_max", o_out_max, exp_q[0].m);
          chk("pair_elem", o_out_elem, exp_q[0].e);
          chk("pair_last", o_out_last, exp_q[0].last);
          chk("pair_len_err", o_len_err, exp_q[0].err);
          chk_after = exp_q[0].last;
          void'(exp_q.pop_front());
          xfers++;
        end
      end
      stall_prev = o_out_valid && !d_ready;
      s_max  = o_out_max;
      s_elem = o_out_elem;
      s_last = o_out_last;
    end
    if (stop_after == 0) chk("drained_within_budget", in_q.size() + exp_q.size(), 0);
    @(negedge clk);
    if (chk_first) chk("first_valid_latency", o_out_valid, 1);
    if (chk_after) begin
      chk("in_ready_after_last", o_in_ready, 1);
      chk("out_valid_after_last", o_out_valid, 0);
      chk("out_last_after_last", o_out_last, 0);
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    d_ready = 1'b0;
  endtask

  task automatic reset_mid_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_last", o_out_last, 0);
    chk("rst_len_err", o_len_err, 0);
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_out_max", o_out_max, 0);
    chk("rst_out_elem", o_out_elem, 0);
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // Reset values on both instances
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_in_ready", ifa.in_ready, 1);
    chk("reset_a_out_valid", ifa.out_valid, 0);
    chk("reset_a_out_last", ifa.out_last, 0);
    chk("reset_a_out_max", ifa.out_max, 0);
    chk("reset_a_out_elem", ifa.out_elem, 0);
    chk("reset_a_len_err", ifa.len_err, 0);
    chk("reset_b_in_ready", ifb.in_ready, 1);
    chk("reset_b_out_valid", ifb.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vector, full throughput
    sel = 1'b0;
    push(3, 0); push(9, 0); push(2, 0); push(9, 0); push(5, 1);
    build(64); run(0, 64, 0, 60);

    // Same vector under backpressure
    push(3, 0); push(9, 0); push(2, 0); push(9, 0); push(5, 1);
    build(64); run(1, 64, 0, 80);

    // Edge values: single all-ones element, then a pair of zeros
    push(16'hFFFF, 1); push(0, 0); push(0, 1);
    build(64); run(0, 64, 0, 60);

    // Back-to-back vectors with in_valid held high
    push(100, 0); push(16'hFFF0, 0); push(7, 1);
    push(1, 0); push(2, 0); push(3, 1);
    build(64); run(0, 64, 0, 80);

    // Overflow on the MAX_LEN=4 instance; leftover beats form the next vector
    sel = 1'b1;
    push(1, 0); push(7, 0); push(3, 0); push(4, 0); push(8, 0); push(2, 1);
    build(4); run(0, 4, 0, 60);

    // Async reset mid-EMIT of a truncated vector clears len_err
    push(10, 0); push(20, 0); push(5, 0); push(30, 0);
    build(4); run(0, 4, 1, 60);
    chk("len_err_before_reset", o_len_err, 1);
    reset_mid_cycle();

    // Async reset mid-EMIT after 2 of 5 pairs, then vector {4,1}
    sel = 1'b0;
    push(3, 0); push(9, 0); push(2, 0); push(9, 0); push(5, 1);
    build(64); run(0, 64, 2, 60);
    reset_mid_cycle();
    push(4, 0); push(1, 1);
    build(64); run(0, 64, 0, 40);

    // Random vectors on the deep instance, including one longer than 64
    for (int v = 0; v < 5; v++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) push(rnd_data(), k == n - 1);
    end
    for (int k = 0; k < 66; k++) push(rnd_data(), k == 65);
    build(64); run(2, 64, 0, 1000);

    // Random vectors on the shallow instance, frequent truncation
    sel = 1'b1;
    for (int v = 0; v < 8; v++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) push(rnd_data(), k == n - 1);
    end
    build(4); run(2, 4, 0, 600);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
